// File: rtl/h264intra4x4_mode_decoder.sv
// Rebuilds Intra4x4PredMode for the 16 sub-blocks of a macroblock from the parsed
// prev_flag/rem_mode pairs, tracking left-MB and top-MB (line buffer) context.
module h264intra4x4_mode_decoder #(
  parameter int MBWIDTH = 120,
  parameter int MBXBITS = 7
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       NEWSLICE,
  input  logic       NEWLINE,
  input  logic       STROBEI,
  input  logic       PREVFLAG,
  input  logic [2:0] REMMODE,
  input  logic       MBSKIP,
  output logic       READYI,
  output logic       STROBEO,
  input  logic       READYO,
  output logic [3:0] MODEO,
  output logic [3:0] SUBMBO,
  output logic       MBDONE
);

  // state   | meaning
  // S_FETCH | read linebuf[mbx] into toprow
  // S_READY | wait for STROBEI/MBSKIP, or apply pending line/slice start
  // S_OUT   | MODEO presented, wait for READYO
  // S_WB    | MB finished: write back context, advance mbx
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_READY = 2'd1,
    S_OUT   = 2'd2,
    S_WB    = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [MBXBITS-1:0] mbx_q, mbx_d;
  logic               lvalid_q, lvalid_d;
  logic               tvalid_q, tvalid_d;
  logic               pend_nl_q, pend_nl_d;
  logic               pend_ns_q, pend_ns_d;
  logic [3:0]         cur_q [16];
  logic [3:0]         cur_d [16];
  logic [3:0]         left_q [4];
  logic [3:0]         left_d [4];
  logic [3:0]         toprow_q [4];
  logic [3:0]         toprow_d [4];
  logic [3:0]         modeo_q, modeo_d;
  logic [3:0]         submbo_q, submbo_d;
  logic               strobeo_q, strobeo_d;

  logic [15:0]        linebuf_mem [MBWIDTH];
  logic [15:0]        lb_rdata;
  logic [15:0]        lb_wdata;
  logic               lb_we;

  logic               readyi;
  logic               pend_any;
  logic               apply_pend;
  logic [1:0]         xx, yy;
  logic               l_avail, t_avail;
  logic [3:0]         l_mode, t_mode;
  logic [3:0]         pred, rem_ext, mode;

  function automatic logic [3:0] blk_idx(input logic [1:0] x, input logic [1:0] y);
    return {y[1], x[1], y[0], x[0]};
  endfunction

  assign xx       = {submbo_q[2], submbo_q[0]};
  assign yy       = {submbo_q[3], submbo_q[1]};
  assign pend_any = pend_nl_q | pend_ns_q;

  // bottom row packed with xx=0 in the low nibble
  assign lb_wdata = {cur_q[15], cur_q[14], cur_q[11], cur_q[10]};
  assign lb_rdata = linebuf_mem[mbx_q];

  always_comb begin : mode_calc
    if (xx != 2'd0) begin
      l_avail = 1'b1;
      l_mode  = cur_q[blk_idx(xx - 2'd1, yy)];
    end else begin
      l_avail = lvalid_q;
      l_mode  = left_q[yy];
    end
    if (yy != 2'd0) begin
      t_avail = 1'b1;
      t_mode  = cur_q[blk_idx(xx, yy - 2'd1)];
    end else begin
      t_avail = tvalid_q;
      t_mode  = toprow_q[xx];
    end
    if (l_avail && t_avail) begin
      pred = (l_mode < t_mode) ? l_mode : t_mode;
    end else begin
      pred = 4'd2;
    end
    rem_ext = {1'b0, REMMODE};
    if (PREVFLAG) begin
      mode = pred;
    end else if (rem_ext < pred) begin
      mode = rem_ext;
    end else begin
      mode = rem_ext + 4'd1;
    end
  end

  always_comb begin : next_state
    state_d    = state_q;
    mbx_d      = mbx_q;
    lvalid_d   = lvalid_q;
    tvalid_d   = tvalid_q;
    cur_d      = cur_q;
    left_d     = left_q;
    toprow_d   = toprow_q;
    modeo_d    = modeo_q;
    submbo_d   = submbo_q;
    strobeo_d  = strobeo_q;
    lb_we      = 1'b0;
    readyi     = 1'b0;
    apply_pend = 1'b0;

    case (state_q)
      S_FETCH: begin
        for (int i = 0; i < 4; i++) begin
          toprow_d[i] = lb_rdata[4*i +: 4];
        end
        state_d = S_READY;
      end
      S_READY: begin
        if ((submbo_q == 4'd0) && pend_any) begin
          apply_pend = 1'b1;
          state_d    = S_FETCH;
        end else begin
          readyi = 1'b1;
          if (MBSKIP) begin
            for (int i = 0; i < 16; i++) begin
              cur_d[i] = 4'd2;
            end
            state_d = S_WB;
          end else if (STROBEI) begin
            cur_d[submbo_q] = mode;
            modeo_d         = mode;
            strobeo_d       = 1'b1;
            state_d         = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (READYO) begin
          strobeo_d = 1'b0;
          if (submbo_q == 4'd15) begin
            submbo_d = 4'd0;
            state_d  = S_WB;
          end else begin
            submbo_d = submbo_q + 4'd1;
            state_d  = S_READY;
          end
        end
      end
      S_WB: begin
        lb_we     = 1'b1;
        left_d[0] = cur_q[5];
        left_d[1] = cur_q[7];
        left_d[2] = cur_q[13];
        left_d[3] = cur_q[15];
        lvalid_d  = 1'b1;
        submbo_d  = 4'd0;
        if (pend_any) begin
          apply_pend = 1'b1;
        end else if (mbx_q == MBXBITS'(MBWIDTH - 1)) begin
          // end of picture line without an explicit NEWLINE
          mbx_d    = '0;
          lvalid_d = 1'b0;
          tvalid_d = 1'b1;
        end else begin
          mbx_d = mbx_q + 1'b1;
        end
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    if (apply_pend) begin
      mbx_d    = '0;
      lvalid_d = 1'b0;
      tvalid_d = !pend_ns_q;
    end
    // a pulse landing in the apply cycle survives for the next boundary
    pend_nl_d = (pend_nl_q & !apply_pend) | NEWLINE;
    pend_ns_d = (pend_ns_q & !apply_pend) | NEWSLICE;
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_q   <= S_FETCH;
      mbx_q     <= '0;
      lvalid_q  <= 1'b0;
      tvalid_q  <= 1'b0;
      pend_nl_q <= 1'b0;
      pend_ns_q <= 1'b0;
      modeo_q   <= 4'd0;
      submbo_q  <= 4'd0;
      strobeo_q <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        cur_q[i] <= 4'd0;
      end
      for (int i = 0; i < 4; i++) begin
        left_q[i]   <= 4'd0;
        toprow_q[i] <= 4'd0;
      end
    end else begin
      state_q   <= state_d;
      mbx_q     <= mbx_d;
      lvalid_q  <= lvalid_d;
      tvalid_q  <= tvalid_d;
      pend_nl_q <= pend_nl_d;
      pend_ns_q <= pend_ns_d;
      modeo_q   <= modeo_d;
      submbo_q  <= submbo_d;
      strobeo_q <= strobeo_d;
      cur_q     <= cur_d;
      left_q    <= left_d;
      toprow_q  <= toprow_d;
    end
  end

  // contents are meaningless until written; tvalid masks them
  always_ff @(posedge CLK) begin
    if (lb_we) begin
      linebuf_mem[mbx_q] <= lb_wdata;
    end
  end

  assign READYI  = readyi;
  assign STROBEO = strobeo_q;
  assign MODEO   = modeo_q;
  assign SUBMBO  = submbo_q;
  assign MBDONE  = (state_q == S_WB);

endmodule

// File: tb/tb_h264intra4x4_mode_decoder.sv
// Bench for h264intra4x4_mode_decoder: picture-level mode model with slice ownership
// per macroblock, a scoreboard compared on every STROBEO cycle, and literal pins.
module tb_h264intra4x4_mode_decoder;

  localparam int MBW  = 4;
  localparam int MBXB = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       newslice, newline, strobei, prevflag, mbskip, readyo;
  logic [2:0] remmode;
  logic       readyi, strobeo, mbdone;
  logic [3:0] modeo, submbo;

  int checks = 0;
  int errors = 0;
  int exp_mode[$];
  int exp_sub[$];
  int got_mbdone = 0;
  int exp_mbdone = 0;

  // picture model: modes by absolute block position, slice id per macroblock
  int pic_mode [64][16];
  int mb_slice [16][MBW];
  int m_row = 0, m_col = 0, m_slice = 0, m_sub = 0;

  always #5 clk = ~clk;

  h264intra4x4_mode_decoder #(.MBWIDTH(MBW), .MBXBITS(MBXB)) dut (
    .CLK(clk), .RESETN(rst_n), .NEWSLICE(newslice), .NEWLINE(newline),
    .STROBEI(strobei), .PREVFLAG(prevflag), .REMMODE(remmode), .MBSKIP(mbskip),
    .READYI(readyi), .STROBEO(strobeo), .READYO(readyo), .MODEO(modeo),
    .SUBMBO(submbo), .MBDONE(mbdone)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic void m_new_row();
    m_row++;
    m_col = 0;
    for (int c = 0; c < MBW; c++) mb_slice[m_row % 16][c] = -1;
  endfunction

  function automatic void m_slice_start();
    m_slice++;
    m_new_row();
  endfunction

  function automatic void m_line_start();
    if (m_col != 0) m_new_row();
  endfunction

  function automatic bit m_avail(input int bx, input int by);
    if (bx < 0 || by < 0) return 1'b0;
    return mb_slice[(by / 4) % 16][bx / 4] == m_slice;
  endfunction

  function automatic int m_bx();
    return m_col * 4 + (m_sub % 2) + 2 * ((m_sub / 4) % 2);
  endfunction

  function automatic int m_by();
    return m_row * 4 + ((m_sub / 2) % 2) + 2 * (m_sub / 8);
  endfunction

  function automatic int m_pred();
    int bx, by, l, t;
    bx = m_bx();
    by = m_by();
    if (m_sub == 0) mb_slice[m_row % 16][m_col] = m_slice;
    if (m_avail(bx - 1, by) && m_avail(bx, by - 1)) begin
      l = pic_mode[by % 64][bx - 1];
      t = pic_mode[(by - 1) % 64][bx];
      return (l < t) ? l : t;
    end
    return 2;
  endfunction

  function automatic void m_mb_end();
    exp_mbdone++;
    m_sub = 0;
    m_col++;
    if (m_col == MBW) m_new_row();
  endfunction

  function automatic void m_store(input int mode);
    pic_mode[m_by() % 64][m_bx()] = mode;
    m_sub++;
    if (m_sub == 16) m_mb_end();
  endfunction

  function automatic void m_skip();
    mb_slice[m_row % 16][m_col] = m_slice;
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++)
        pic_mode[(m_row * 4 + y) % 64][m_col * 4 + x] = 2;
    m_mb_end();
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (readyi !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (readyi !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: readyi=%0b after %0d cycles, expected 1", readyi, n);
    end
  endtask

  task automatic send_blk(input bit flag, input int rem, output int mode);
    int pred;
    wait_ready();
    pred = m_pred();
    mode = flag ? pred : ((rem < pred) ? rem : rem + 1);
    exp_mode.push_back(mode);
    exp_sub.push_back(m_sub);
    m_store(mode);
    strobei  = 1'b1;
    prevflag = flag;
    remmode  = 3'(rem);
    @(posedge clk);
    #1;
    strobei = 1'b0;
  endtask

  // pick flag/rem so that the block decodes to tgt
  task automatic send_mode(input int tgt);
    int pred, m;
    pred = m_pred();
    if (pred == tgt) send_blk(1'b1, 0, m);
    else send_blk(1'b0, (tgt < pred) ? tgt : tgt - 1, m);
  endtask

  task automatic send_skip();
    wait_ready();
    m_skip();
    mbskip = 1'b1;
    @(posedge clk);
    #1;
    mbskip = 1'b0;
  endtask

  task automatic pulse_ns();
    newslice = 1'b1;
    m_slice_start();
    @(posedge clk);
    #1;
    newslice = 1'b0;
  endtask

  task automatic pulse_nl();
    newline = 1'b1;
    m_line_start();
    @(posedge clk);
    #1;
    newline = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      exp_mode.delete();
      exp_sub.delete();
    end else begin
      if (mbdone === 1'b1) got_mbdone++;
      if (strobeo === 1'b1) begin
        chk("readyi_during_out", int'(readyi), 0);
        if (exp_mode.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobeo: modeo=%0d submbo=%0d, expected no output", modeo, submbo);
        end else begin
          chk("modeo", int'(modeo), exp_mode[0]);
          chk("submbo", int'(submbo), exp_sub[0]);
          if (readyo === 1'b1) begin
            void'(exp_mode.pop_front());
            void'(exp_sub.pop_front());
          end
        end
      end
    end
  end

  initial begin
    int m, n;
    rst_n = 1'b0; newslice = 1'b0; newline = 1'b0; strobei = 1'b0;
    prevflag = 1'b0; remmode = 3'd0; mbskip = 1'b0; readyo = 1'b1;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < MBW; c++) mb_slice[r][c] = -1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_readyi", int'(readyi), 0);
    chk("rst_strobeo", int'(strobeo), 0);
    chk("rst_modeo", int'(modeo), 0);
    chk("rst_submbo", int'(submbo), 0);
    chk("rst_mbdone", int'(mbdone), 0);
    rst_n = 1'b1;
    m_slice_start();

    // T1: fresh slice, all predicted -> every mode 2
    pulse_ns();
    for (int b = 0; b < 16; b++) begin
      send_blk(1'b1, 0, m);
      chk("t1_mode", m, 2);
    end

    // T2: first MB of a slice with explicit rem modes
    pulse_ns();
    send_blk(1'b0, 1, m); chk("t2_rem1", m, 1);
    for (int b = 1; b < 16; b++) send_blk(1'b1, 0, m);
    pulse_ns();
    send_blk(1'b0, 2, m); chk("t2_rem2", m, 3);
    for (int b = 1; b < 16; b++) send_blk(1'b1, 0, m);
    pulse_ns();
    send_blk(1'b0, 7, m); chk("t2_rem7", m, 8);
    for (int b = 1; b < 16; b++) send_blk(1'b1, 0, m);

    // T3: all-zero MB on line 0, then NEWLINE
    pulse_ns();
    for (int b = 0; b < 16; b++) send_mode(0);
    pulse_nl();
    send_blk(1'b1, 0, m); chk("t3_blk0_noleft", m, 2);
    send_blk(1'b1, 0, m); chk("t3_blk1_top0", m, 0);
    for (int b = 2; b < 16; b++) send_blk(1'b1, 0, m);

    // T4: backpressure hold on block 3
    pulse_ns();
    for (int b = 0; b < 3; b++) send_blk(1'b1, 0, m);
    send_blk(1'b0, 5, m);
    readyo = 1'b0;
    repeat (5) @(negedge clk);
    chk("t4_hold_strobeo", int'(strobeo), 1);
    chk("t4_hold_submbo", int'(submbo), 3);
    chk("t4_hold_modeo", int'(modeo), 6);
    chk("t4_hold_readyi", int'(readyi), 0);
    @(posedge clk);
    #1;
    readyo = 1'b1;
    for (int b = 4; b < 16; b++) send_blk(1'b0, b % 8, m);

    // T5: skipped MB as left neighbour, zero modes above
    pulse_ns();
    for (int b = 0; b < 32; b++) send_mode(0);
    pulse_nl();
    send_skip();
    send_blk(1'b1, 0, m); chk("t5_after_skip", m, 0);
    for (int b = 1; b < 16; b++) send_blk(1'b1, 0, m);

    // mixed MBs across implicit line wraps
    pulse_ns();
    for (int mb = 0; mb < 10; mb++) begin
      if ($urandom_range(4) == 0) send_skip();
      else for (int b = 0; b < 16; b++)
        send_blk(1'($urandom_range(1)), int'($urandom_range(7)), m);
    end

    // T6: reset while block 7 is being presented
    for (int b = 0; b < 8; b++) send_blk(1'b1, 0, m);
    chk("t6_pre_submbo", int'(submbo), 7);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("t6_readyi", int'(readyi), 0);
    chk("t6_strobeo", int'(strobeo), 0);
    chk("t6_modeo", int'(modeo), 0);
    chk("t6_submbo", int'(submbo), 0);
    chk("t6_mbdone", int'(mbdone), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_sub = 0;
    m_slice_start();
    for (int b = 0; b < 16; b++) begin
      send_blk(1'b1, 0, m);
      chk("t6_mode", m, 2);
    end

    n = 0;
    while (exp_mode.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_mode.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d outputs outstanding, expected 0", exp_mode.size());
    end
    repeat (4) @(posedge clk);
    #1;
    chk("mbdone_count", got_mbdone, exp_mbdone);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
